fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and buffers
// fetched words in a small circular prefetch queue feeding decode.
module fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter int          AW       = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_a,
    input  logic [31:0]   imem_rd,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          id_ready,
    output logic          id_valid,
    output logic [31:0]   id_instr,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_pcplus4
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] FULL    = (PW + 1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]   pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          deq;
    logic          enq;

    assign imem_a   = pc[AW+1:2];
    assign id_valid = (count != '0);
    assign deq      = id_valid & id_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign enq      = ~redirect & ((count < FULL) | deq);

    // Control state: PC, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Queue payload is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[wr_ptr] <= imem_rd;
            q_pc[wr_ptr]    <= pc;
        end
    end

    always_comb begin
        id_instr   = 32'd0;
        id_pc      = 32'd0;
        id_pcplus4 = 32'd0;
        if (id_valid) begin
            id_instr   = q_instr[rd_ptr];
            id_pc      = q_pc[rd_ptr];
            id_pcplus4 = q_pc[rd_ptr] + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a
// queue-based model of the instruction stream decode should observe.
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam int          AW       = 6;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] imem_a;
    logic [31:0]   imem_rd;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          id_ready;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [31:0]   id_pc;
    logic [31:0]   id_pcplus4;

    logic [31:0] mem [2**AW];
    ent_t        mq[$];
    logic [31:0] mpc;
    bit          model_ok;
    int          n_cmp;
    int          n_bad;

    fetch_stage #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pcplus4  (id_pcplus4)
    );

    assign imem_rd = mem[imem_a];

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: compare outputs with the model, then apply one
    // cycle of inputs to both and advance to the next falling edge.
    task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        ent_t e;
        bit   d;
        bit   en;
        if (model_ok) begin
            check_val("valid", 32'(id_valid), 32'(mq.size() > 0));
            check_val("imem_a", 32'(imem_a), 32'(mpc[AW+1:2]));
            if (mq.size() > 0) begin
                e = mq[0];
                check_val("instr", id_instr, e.instr);
                check_val("pc", id_pc, e.pc);
                check_val("pcplus4", id_pcplus4, e.pc + 32'd4);
            end else begin
                check_val("instr_idle", id_instr, 32'd0);
                check_val("pc_idle", id_pc, 32'd0);
                check_val("pcplus4_idle", id_pcplus4, 32'd0);
            end
        end
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        id_ready    = rdy;
        d = (mq.size() > 0) && rdy;
        if (rst) begin
            mq.delete();
            mpc      = RESET_PC;
            model_ok = 1'b1;
        end else if (redir) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            en = (mq.size() < DEPTH) || d;
            if (d) void'(mq.pop_front());
            if (en) begin
                e.instr = mem[mpc[AW+1:2]];
                e.pc    = mpc;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        id_ready = 1'b0;
        model_ok = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < 2**AW; k++) mem[k] = 32'h1000_0000 + 32'(k);
        @(negedge clk);

        // Streaming with decode always ready.
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check_val("rst_valid", 32'(id_valid), 32'd0);
        check_val("rst_imem_a", 32'(imem_a), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("first_instr", id_instr, 32'h1000_0000);
        check_val("first_pc", id_pc, 32'h0);
        check_val("first_pcplus4", id_pcplus4, 32'h4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("stream_pc", id_pc, 32'h10);
        check_val("stream_instr", id_instr, 32'h1000_0004);

        // Stall fills the queue and freezes the PC, then drains in order.
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check_val("stall_imem_a", 32'(imem_a), 32'd2);
        check_val("stall_head", id_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check_val("drain_pc", id_pc, 32'(4 * i));
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
        end

        // Redirect while full and stalled.
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h43, 1'b0);
        check_val("redir_valid", 32'(id_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check_val("redir_pc", id_pc, 32'h40);
        check_val("redir_instr", id_instr, 32'h1000_0010);
        check_val("redir_imem_a", 32'(imem_a), 32'd17);

        // Redirect in the same cycle the head is consumed.
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h80, 1'b1);
        check_val("consume_valid", 32'(id_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("consume_next_pc", id_pc, 32'h80);

        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check_val("wrap_imem_a", 32'(imem_a), 32'd63);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check_val("wrap_pcplus4", id_pcplus4, 32'h0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("wrap_next_pc", id_pc, 32'h0);

        // Reset mid-stream with one entry queued.
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check_val("midrst_valid", 32'(id_valid), 32'd0);
        check_val("midrst_imem_a", 32'(imem_a), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("midrst_pc", id_pc, 32'h0);

        // Random traffic with random memory contents.
        for (int k = 0; k < 2**AW; k++) mem[k] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) < 2);
            rd = ($urandom_range(0, 99) < 10);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle(r, rd, t, 1'($urandom_range(0, 99) < 65));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
